// File: rtl/floo_pkg.sv
// floo_pkg: shared routing definitions for the FlooNoC routing stage.
`default_nettype none

package floo_pkg;

    typedef enum logic [1:0] {
        IdTable       = 2'd0,
        XYRouting     = 2'd1,
        SourceRouting = 2'd2
    } route_algo_e;

endpackage

`default_nettype wire

// File: rtl/floo_route_comp.sv
// floo_route_comp: combinational destination-ID decode from a request address.
`default_nettype none

module floo_route_comp
    import floo_pkg::*;
#(
    parameter route_algo_e RouteAlgo     = IdTable,
    parameter bit          UseIdTable    = 1'b1,
    parameter int unsigned XYAddrOffsetX = 0,
    parameter int unsigned XYAddrOffsetY = 0,
    parameter int unsigned IdAddrOffset  = 0,
    parameter int unsigned NumRules      = 0,
    parameter type         id_t          = logic,
    parameter type         id_rule_t     = logic,
    parameter id_rule_t [NumRules-1:0] AddrMap = '0,
    parameter type         addr_t        = logic
) (
    input  addr_t addr_i,
    output id_t   id_o
);

    localparam int unsigned AW = $bits(addr_t);
    localparam int unsigned IW = $bits(id_t);

    // Only a few address bits feed the decode in direct modes.
    logic unused_addr;
    assign unused_addr = ^addr_i;

    if (UseIdTable && (RouteAlgo == IdTable || RouteAlgo == XYRouting)) begin : g_table
        // Rules are laid out as {idx, start_addr, end_addr}; first match wins.
        localparam int unsigned RW = IW + 2 * AW;
        logic [RW-1:0] rule;
        logic [AW-1:0] addr_vec;
        logic          found;
        id_t           id;

        assign addr_vec = AW'(addr_i);

        always_comb begin
            id    = '0;
            found = 1'b0;
            rule  = '0;
            for (int i = 0; i < int'(NumRules); i++) begin
                rule = RW'(AddrMap[i]);
                if (!found && addr_vec >= rule[2*AW-1:AW] && addr_vec < rule[AW-1:0]) begin
                    id    = id_t'(rule[RW-1:2*AW]);
                    found = 1'b1;
                end
            end
        end

        assign id_o = id;
    end else if (!UseIdTable && RouteAlgo == XYRouting) begin : g_xy
        // X occupies the upper half of the ID, Y the lower half.
        localparam int unsigned XW = IW / 2;
        localparam int unsigned YW = IW - XW;
        assign id_o = id_t'({addr_i[XYAddrOffsetX +: XW], addr_i[XYAddrOffsetY +: YW]});
    end else if (!UseIdTable && RouteAlgo == IdTable) begin : g_flat
        assign id_o = id_t'(addr_i[IdAddrOffset +: IW]);
    end else begin : g_invalid
        $error("floo_route_comp: unsupported RouteAlgo/UseIdTable combination");
        assign id_o = '0;
    end

endmodule

`default_nettype wire

// File: rtl/floo_route_stage.sv
// floo_route_stage: routing decode followed by a fully registered 2-entry skid buffer
// and a saturating count of forwarded requests.
`default_nettype none

module floo_route_stage
    import floo_pkg::*;
#(
    parameter route_algo_e RouteAlgo     = IdTable,
    parameter bit          UseIdTable    = 1'b1,
    parameter int unsigned XYAddrOffsetX = 0,
    parameter int unsigned XYAddrOffsetY = 0,
    parameter int unsigned IdAddrOffset  = 0,
    parameter int unsigned NumRules      = 0,
    parameter type         id_t          = logic,
    parameter type         id_rule_t     = logic,
    parameter id_rule_t [NumRules-1:0] AddrMap = '0,
    parameter type         addr_t        = logic,
    parameter type         payload_t     = logic,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  addr_t               addr_i,
    input  payload_t            payload_i,
    output logic                valid_o,
    input  logic                ready_i,
    output id_t                 dst_id_o,
    output payload_t            payload_o,
    input  logic                clr_cnt_i,
    output logic [CntWidth-1:0] cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e   state;
    id_t      dec_id;
    id_t      skid_dst;
    payload_t skid_payload;
    logic     push;
    logic     pop;

    floo_route_comp #(
        .RouteAlgo     (RouteAlgo),
        .UseIdTable    (UseIdTable),
        .XYAddrOffsetX (XYAddrOffsetX),
        .XYAddrOffsetY (XYAddrOffsetY),
        .IdAddrOffset  (IdAddrOffset),
        .NumRules      (NumRules),
        .id_t          (id_t),
        .id_rule_t     (id_rule_t),
        .AddrMap       (AddrMap),
        .addr_t        (addr_t)
    ) i_route_comp (
        .addr_i (addr_i),
        .id_o   (dec_id)
    );

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // HEAD is the output register itself; valid/ready are registered copies of the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= EMPTY;
            valid_o      <= 1'b0;
            ready_o      <= 1'b0;
            dst_id_o     <= '0;
            payload_o    <= '0;
            skid_dst     <= '0;
            skid_payload <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    ready_o <= 1'b1;
                    if (push) begin
                        state     <= ONE;
                        valid_o   <= 1'b1;
                        dst_id_o  <= dec_id;
                        payload_o <= payload_i;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        dst_id_o  <= dec_id;
                        payload_o <= payload_i;
                    end else if (push) begin
                        state        <= FULL;
                        ready_o      <= 1'b0;
                        skid_dst     <= dec_id;
                        skid_payload <= payload_i;
                    end else if (pop) begin
                        state   <= EMPTY;
                        valid_o <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state     <= ONE;
                        ready_o   <= 1'b1;
                        dst_id_o  <= skid_dst;
                        payload_o <= skid_payload;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Clear wins over a coinciding transfer; the count sticks at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_cnt_i) begin
            cnt_o <= '0;
        end else if (pop && (cnt_o != {CntWidth{1'b1}})) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (valid_o && $stable(dst_id_o) && $stable(payload_o)));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == FULL) |-> !push);
`endif

endmodule

`default_nettype wire

// File: tb/tb_floo_route_stage.sv
// tb_floo_route_stage: directed and random checks of floo_route_stage against a queue model.
`default_nettype none

module tb_floo_route_stage;
    import floo_pkg::*;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } id_t;
    typedef logic [31:0] addr_t;
    typedef logic [7:0]  payload_t;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     valid_i = 1'b0;
    logic     ready_o;
    addr_t    addr_i = '0;
    payload_t payload_i = '0;
    logic     valid_o;
    logic     ready_i = 1'b0;
    id_t      dst_id_o;
    payload_t payload_o;
    logic     clr_cnt_i = 1'b0;
    logic [3:0] cnt_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] q[$];
    int          mcnt   = 0;
    bit          mready = 1'b0;

    always #5 clk = ~clk;

    floo_route_stage #(
        .RouteAlgo     (XYRouting),
        .UseIdTable    (1'b0),
        .XYAddrOffsetX (16),
        .XYAddrOffsetY (20),
        .IdAddrOffset  (0),
        .NumRules      (0),
        .id_t          (id_t),
        .id_rule_t     (logic),
        .addr_t        (addr_t),
        .payload_t     (payload_t),
        .CntWidth      (4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .addr_i    (addr_i),
        .payload_i (payload_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .dst_id_o  (dst_id_o),
        .payload_o (payload_o),
        .clr_cnt_i (clr_cnt_i),
        .cnt_o     (cnt_o)
    );

    // X is the address nibble at bit 16, Y the nibble at bit 20; ID = x*16 + y.
    function automatic logic [7:0] ref_dst(input logic [31:0] a);
        int x;
        int y;
        x = int'((a >> 16) % 16);
        y = int'((a >> 20) % 16);
        return 8'(x * 16 + y);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("valid_o", 32'(valid_o), 32'(q.size() > 0));
        chk("ready_o", 32'(ready_o), 32'(mready));
        chk("cnt_o", 32'(cnt_o), 32'(mcnt));
        if (q.size() > 0) begin
            chk("dst_id_o", 32'(dst_id_o), 32'(q[0][15:8]));
            chk("payload_o", 32'(payload_o), 32'(q[0][7:0]));
        end
    endtask

    task automatic cyc();
        bit push;
        bit pop;
        push = valid_i && mready;
        pop  = (q.size() > 0) && ready_i;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mcnt   = 0;
            mready = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({ref_dst(addr_i), payload_i});
            if (clr_cnt_i) mcnt = 0;
            else if (pop && mcnt < 15) mcnt++;
            mready = (q.size() < 2);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        // Reset held for three cycles
        #1;
        check_outputs();
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_release_ready", 32'(ready_o), 32'd1);

        // Single request
        valid_i = 1'b1; addr_i = 32'h0052_0000; payload_i = 8'hA5; ready_i = 1'b1;
        cyc();
        chk("single_dst", 32'(dst_id_o), 32'h25);
        chk("single_payload", 32'(payload_o), 32'hA5);
        valid_i = 1'b0;
        cyc();
        chk("single_cnt", 32'(cnt_o), 32'd1);

        // Backpressure: fill both slots, then drain in push order
        ready_i = 1'b0;
        valid_i = 1'b1; addr_i = 32'h0013_0000; payload_i = 8'h11;
        cyc();
        addr_i = 32'h0031_0000; payload_i = 8'h22;
        cyc();
        valid_i = 1'b0;
        chk("bp_full_ready", 32'(ready_o), 32'd0);
        chk("bp_head_first", 32'(dst_id_o), 32'h31);
        ready_i = 1'b1;
        cyc();
        chk("bp_head_second", 32'(dst_id_o), 32'h13);
        chk("bp_ready_back", 32'(ready_o), 32'd1);
        cyc();
        chk("bp_drained", 32'(valid_o), 32'd0);

        // Streaming: ten back-to-back requests from a cleared counter
        clr_cnt_i = 1'b1;
        cyc();
        clr_cnt_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1; addr_i = $urandom; payload_i = 8'($urandom);
            cyc();
        end
        valid_i = 1'b0;
        cyc();
        chk("stream_cnt", 32'(cnt_o), 32'd10);

        // Saturation, then a clear that coincides with a transfer
        for (int i = 0; i < 20; i++) begin
            valid_i = 1'b1; addr_i = $urandom; payload_i = 8'($urandom);
            cyc();
        end
        valid_i = 1'b0;
        cyc();
        chk("sat_cnt", 32'(cnt_o), 32'd15);
        valid_i = 1'b1; addr_i = $urandom; payload_i = 8'($urandom);
        cyc();
        valid_i = 1'b0; clr_cnt_i = 1'b1;
        cyc();
        clr_cnt_i = 1'b0;
        chk("clr_with_transfer", 32'(cnt_o), 32'd0);

        // Random traffic with random backpressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            valid_i   = ($urandom_range(0, 3) != 0);
            ready_i   = ($urandom_range(0, 2) != 0);
            clr_cnt_i = ($urandom_range(0, 31) == 0);
            addr_i    = $urandom;
            payload_i = 8'($urandom);
            cyc();
        end
        clr_cnt_i = 1'b0;

        // Mid-operation reset from FULL, asserted between edges
        valid_i = 1'b0; ready_i = 1'b0;
        cyc();
        cyc();
        valid_i = 1'b1; addr_i = 32'h0077_0000; payload_i = 8'h5A;
        cyc();
        addr_i = 32'h0066_0000; payload_i = 8'h6B;
        cyc();
        valid_i = 1'b0;
        chk("pre_reset_full", 32'(ready_o), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        mcnt   = 0;
        mready = 1'b0;
        chk("async_rst_valid", 32'(valid_o), 32'd0);
        chk("async_rst_ready", 32'(ready_o), 32'd0);
        chk("async_rst_cnt", 32'(cnt_o), 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        ready_i = 1'b1;
        repeat (5) cyc();
        chk("no_stale_output", 32'(valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
